// File: rtl/bp_me_wb_ram.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_wb_ram
// Purpose  : Wishbone B4 slave memory model. 64-bit wide, byte-maskable SRAM
//            behind a single Wishbone port. Terminates the bus driven by
//            bp_me_wb_master. Supports classic single cycles and
//            registered-feedback bursts (constant, linear, wrap-4/8/16).
// Ports    : clk_i    - clock, rising edge
//            reset_i  - synchronous active-high reset
//            adr_i    - word address of the current beat
//            dat_i    - write data
//            dat_o    - read data (zero while ack_o is low)
//            sel_i    - byte enables
//            we_i     - 1 = write, 0 = read
//            cyc_i    - bus cycle active
//            stb_i    - beat strobe
//            cti_i    - cycle type identifier
//            bte_i    - burst type extension
//            ack_o    - beat completed normally
//            err_o    - beat terminated with error (address out of range)
//            rty_o    - retry, never asserted
// Revision : 1.0 - initial release
// ============================================================================
module bp_me_wb_ram #(
    parameter int adr_width_p   = 37,
    parameter int els_p         = 512,
    parameter int base_adr_p    = 0,
    parameter int wait_cycles_p = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [adr_width_p-1:0] adr_i,
    input  logic [63:0]            dat_i,
    output logic [63:0]            dat_o,
    input  logic [7:0]             sel_i,
    input  logic                   we_i,
    input  logic                   cyc_i,
    input  logic                   stb_i,
    input  logic [2:0]             cti_i,
    input  logic [1:0]             bte_i,
    output logic                   ack_o,
    output logic                   err_o,
    output logic                   rty_o
);

    localparam int                     c_idx_w     = $clog2(els_p);
    localparam logic [adr_width_p-1:0] c_base      = adr_width_p'(base_adr_p);
    localparam logic [adr_width_p-1:0] c_els       = adr_width_p'(els_p);
    localparam logic [2:0]             c_wait_load = 3'(wait_cycles_p - 1);
    localparam logic                   c_no_wait   = (wait_cycles_p == 0);

    localparam logic [2:0] c_cti_const = 3'b001;
    localparam logic [2:0] c_cti_incr  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    logic [63:0] mem [els_p];

    state_e                   state_q, state_d;
    logic [adr_width_p-1:0]   cur_adr_q, cur_adr_d;
    logic [2:0]               cnt_q, cnt_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [63:0]              dat_q, dat_d;

    logic                     w_req;
    logic                     w_wr_en;
    logic [adr_width_p-1:0]   w_inc;
    logic [adr_width_p-1:0]   w_wrap_mask;
    logic [adr_width_p-1:0]   w_next_adr;
    logic [adr_width_p-1:0]   w_off_cur;
    logic [adr_width_p-1:0]   w_off_nxt;
    logic                     w_nxt_in_range;
    logic                     w_cti_burst;

    assign w_req       = cyc_i & stb_i;
    assign w_cti_burst = (cti_i == c_cti_const) || (cti_i == c_cti_incr);

    // Offsets relative to the mapped base. A single unsigned compare covers
    // both ends of the window because addresses below base wrap to huge
    // offsets.
    assign w_off_cur      = cur_adr_q - c_base;
    assign w_off_nxt      = cur_adr_d - c_base;
    assign w_nxt_in_range = (w_off_nxt < c_els);

    // Burst address generation. Wrapping bursts only advance the low
    // log2(N) bits; the upper bits of the current address are kept.
    assign w_inc = cur_adr_q + adr_width_p'(1);

    always_comb begin
        w_wrap_mask = '0;
        case (bte_i)
            2'b01:   w_wrap_mask = adr_width_p'(4'h3);
            2'b10:   w_wrap_mask = adr_width_p'(4'h7);
            2'b11:   w_wrap_mask = adr_width_p'(4'hF);
            default: w_wrap_mask = '0;
        endcase
    end

    always_comb begin
        w_next_adr = cur_adr_q;
        if (cti_i == c_cti_incr) begin
            if (bte_i == 2'b00) begin
                w_next_adr = w_inc;
            end else begin
                w_next_adr = (cur_adr_q & ~w_wrap_mask) | (w_inc & w_wrap_mask);
            end
        end
    end

    // Next-state logic. ack_q is only ever set for an in-range beat in RESP,
    // so it doubles as the "this RESP beat succeeded" qualifier.
    always_comb begin
        state_d   = state_q;
        cur_adr_d = cur_adr_q;
        cnt_d     = cnt_q;
        w_wr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    cur_adr_d = adr_i;
                    if (c_no_wait) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = c_wait_load;
                    end
                end
            end

            ST_WAIT: begin
                if (!w_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            ST_RESP: begin
                // Error beats, classic cycles, end-of-burst and aborts all
                // fall back to IDLE.
                state_d = ST_IDLE;
                if (w_req && ack_q) begin
                    w_wr_en = we_i & ~reset_i;
                    if (w_cti_burst) begin
                        cur_adr_d = w_next_adr;
                        if (c_no_wait) begin
                            state_d = ST_RESP;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = c_wait_load;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Responses are registered: they are computed from the state and address
    // the FSM is about to enter, so they line up with the RESP cycle itself.
    always_comb begin
        ack_d = 1'b0;
        err_d = 1'b0;
        dat_d = '0;
        if (state_d == ST_RESP) begin
            if (w_nxt_in_range) begin
                ack_d = 1'b1;
                dat_d = mem[w_off_nxt[c_idx_w-1:0]];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cur_adr_q <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_adr_q <= cur_adr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

    // Storage array, intentionally not reset. Writes land at the end of the
    // acked RESP cycle, one byte lane per select bit.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (sel_i[i]) begin
                    mem[w_off_cur[c_idx_w-1:0]][8*i +: 8] <= dat_i[8*i +: 8];
                end
            end
        end
    end

    assign ack_o = ack_q;
    assign err_o = err_q;
    assign dat_o = dat_q;
    assign rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bp_me_wb_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_me_wb_ram
// Purpose  : Scoreboard bench for bp_me_wb_ram. Two instances share one bus:
//            u_dut0 has no wait states, u_dut2 has two. Stimulus pushes the
//            expected response of every beat; a monitor pops and compares on
//            each ack/err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_me_wb_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [36:0] adr;
    logic [63:0] dat_w;
    logic [7:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        tgt;

    logic [63:0] dat_a, dat_b, dat_m;
    logic        ack_a, ack_b, ack_m;
    logic        err_a, err_b, err_m;
    logic        rty_a, rty_b;

    always #5 clk = ~clk;

    bp_me_wb_ram #(
        .adr_width_p(37), .els_p(512), .base_adr_p(0), .wait_cycles_p(0)
    ) u_dut0 (
        .clk_i(clk), .reset_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_a),
        .sel_i(sel), .we_i(we), .cyc_i(cyc & ~tgt), .stb_i(stb), .cti_i(cti),
        .bte_i(bte), .ack_o(ack_a), .err_o(err_a), .rty_o(rty_a)
    );

    bp_me_wb_ram #(
        .adr_width_p(37), .els_p(512), .base_adr_p(0), .wait_cycles_p(2)
    ) u_dut2 (
        .clk_i(clk), .reset_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_b),
        .sel_i(sel), .we_i(we), .cyc_i(cyc & tgt), .stb_i(stb), .cti_i(cti),
        .bte_i(bte), .ack_o(ack_b), .err_o(err_b), .rty_o(rty_b)
    );

    assign ack_m = tgt ? ack_b : ack_a;
    assign err_m = tgt ? err_b : err_a;
    assign dat_m = tgt ? dat_b : dat_a;

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [63:0] dat;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic e, input logic c, input logic [63:0] d);
        exp_t x;
        x.err = e;
        x.chk = c;
        x.dat = d;
        q.push_back(x);
    endtask

    // Monitor: every response beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_m || err_m) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual ack=%b err=%b required none", ack_m, err_m);
                end else begin
                    m_e = q.pop_front();
                    check("resp_err", {63'd0, err_m}, {63'd0, m_e.err});
                    check("resp_ack", {63'd0, ack_m}, {63'd0, ~m_e.err});
                    if (m_e.chk) check("resp_dat", dat_m, m_e.dat);
                end
            end else begin
                check("idle_dat", dat_m, 64'd0);
            end
        end
    end

    task automatic idle_bus();
        cyc = 0; stb = 0; we = 0; cti = 3'b000; bte = 2'b00;
        sel = 8'h00; adr = '0; dat_w = '0;
    endtask

    // Classic single cycle: checks response latency and that exactly one
    // response is returned.
    task automatic single(input logic w, input logic [36:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic exp_err,
                          input logic [63:0] exp_d, input string name);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s;
        cti = 3'b000; bte = 2'b00;
        push_exp(exp_err, exp_err | ~w, exp_err ? 64'd0 : exp_d);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack_m || err_m) begin
                lat = i;
                break;
            end
        end
        check({name, "_lat"}, 64'(lat), tgt ? 64'd3 : 64'd1);
        @(posedge clk); #1;
        check({name, "_once"}, {62'd0, ack_m, err_m}, 64'd0);
        idle_bus();
    endtask

    // Burst of n beats; expectations are pushed by the caller.
    task automatic burst(input logic w, input logic [36:0] a0, input logic [2:0] ctype,
                         input logic [1:0] bt, input int n, input logic [63:0] d0,
                         input string name);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a0; cti = ctype; bte = bt;
        sel = 8'hFF; dat_w = d0;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            check({name, "_beat"}, {63'd0, ack_m | err_m}, 64'd1);
            cti   = (k == n - 1) ? 3'b111 : ctype;
            dat_w = d0 + 64'(k);
            @(posedge clk); #1;
        end
        check({name, "_end"}, {63'd0, ack_m | err_m}, 64'd0);
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; tgt = 0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", {63'd0, ack_a}, 64'd0);
        check("rst_err0", {63'd0, err_a}, 64'd0);
        check("rst_rty0", {63'd0, rty_a}, 64'd0);
        check("rst_dat0", dat_a, 64'd0);
        check("rst_ack2", {63'd0, ack_b}, 64'd0);
        check("rst_dat2", dat_b, 64'd0);
        rst = 0;

        // Full and partial byte writes
        single(1, 37'h5, 64'h1122334455667788, 8'hFF, 0, 64'd0, "wr5");
        single(0, 37'h5, 64'd0, 8'hFF, 0, 64'h1122334455667788, "rd5");
        single(1, 37'h5, 64'hAAAAAAAABBBBBBBB, 8'h0F, 0, 64'd0, "wr5m");
        single(0, 37'h5, 64'd0, 8'hFF, 0, 64'h11223344BBBBBBBB, "rd5m");

        for (int i = 0; i < 4; i++)
            single(1, 37'h10 + 37'(i), 64'(i), 8'hFF, 0, 64'd0, "pre");

        // Linear incrementing read
        push_exp(0, 1, 64'd0); push_exp(0, 1, 64'd1);
        push_exp(0, 1, 64'd2); push_exp(0, 1, 64'd3);
        burst(0, 37'h10, 3'b010, 2'b00, 4, 64'd0, "incr");

        // Wrap-4 read starting mid-block
        push_exp(0, 1, 64'd2); push_exp(0, 1, 64'd3);
        push_exp(0, 1, 64'd0); push_exp(0, 1, 64'd1);
        burst(0, 37'h12, 3'b010, 2'b01, 4, 64'd0, "wrap4");

        // Constant-address burst
        push_exp(0, 1, 64'd1); push_exp(0, 1, 64'd1); push_exp(0, 1, 64'd1);
        burst(0, 37'h11, 3'b001, 2'b00, 3, 64'd0, "const");

        // Burst write then read back
        push_exp(0, 0, 64'd0); push_exp(0, 0, 64'd0);
        burst(1, 37'h20, 3'b010, 2'b00, 2, 64'hC0, "wrb");
        push_exp(0, 1, 64'hC0); push_exp(0, 1, 64'hC1);
        burst(0, 37'h20, 3'b010, 2'b00, 2, 64'd0, "rdb");

        // Out-of-range accesses; word 0 aliases 0x200 in the index bits
        single(1, 37'h0, 64'hDEADBEEF00000001, 8'hFF, 0, 64'd0, "wr0");
        single(0, 37'h200, 64'd0, 8'hFF, 1, 64'd0, "rd_oor");
        single(1, 37'h200, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, 64'd0, "wr_oor");
        single(0, 37'h0, 64'd0, 8'hFF, 0, 64'hDEADBEEF00000001, "rd0");

        // Linear burst running off the top of memory
        single(1, 37'h1FE, 64'h1FE, 8'hFF, 0, 64'd0, "wr1fe");
        single(1, 37'h1FF, 64'h1FF, 8'hFF, 0, 64'd0, "wr1ff");
        push_exp(0, 1, 64'h1FE); push_exp(0, 1, 64'h1FF); push_exp(1, 1, 64'd0);
        burst(0, 37'h1FE, 3'b010, 2'b00, 3, 64'd0, "cross");

        // Two-wait-state instance
        tgt = 1;
        single(1, 37'h7, 64'h7777, 8'hFF, 0, 64'd0, "w2_wr");
        single(0, 37'h7, 64'd0, 8'hFF, 0, 64'h7777, "w2_rd");

        // Abort during wait: no response may follow
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 37'h7; sel = 8'hFF; cti = 3'b000;
        @(posedge clk); #1;
        idle_bus();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", {62'd0, ack_m, err_m}, 64'd0);
        end
        single(0, 37'h7, 64'd0, 8'hFF, 0, 64'h7777, "w2_rd_after");

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
